// File: rtl/modadd_prefix_pipe.sv
// Pipelined carry resolution and result select for the modular adder (A+B) mod (2^N_BITS - K_CONST).
// Resolves the plain and K-compensated carry chains with a Sklansky prefix network.
module modadd_prefix_pipe #(
  parameter int N_BITS  = 7,
  parameter int K_CONST = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_g,
  input  logic [N_BITS-1:0] in_p,
  input  logic [N_BITS-1:0] in_h,
  input  logic [N_BITS-1:0] in_gp,
  input  logic [N_BITS-1:0] in_pp,
  input  logic [N_BITS-1:0] in_hp,
  input  logic              in_cs_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] out_sum,
  output logic              out_wrap
);

  localparam int LEVELS = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  if (N_BITS < 2 || N_BITS > 32 || K_CONST < 1) begin : g_bad_params
    $error("modadd_prefix_pipe: N_BITS must be 2..32 and K_CONST positive");
  end

  // Sklansky prefix: at level l every bit with index bit l set absorbs the
  // group ending just below its 2^l-aligned block.
  function automatic logic [N_BITS-1:0] prefix_g(input logic [N_BITS-1:0] g,
                                                 input logic [N_BITS-1:0] p);
    logic [N_BITS-1:0] gg, pp, gn, pn;
    int j;
    gg = g;
    pp = p;
    for (int l = 0; l < LEVELS; l++) begin
      gn = gg;
      pn = pp;
      for (int i = 0; i < N_BITS; i++) begin
        if (((i >> l) & 1) == 1) begin
          j     = ((i >> l) << l) - 1;
          gn[i] = gg[i] | (pp[i] & gg[j]);
          pn[i] = pp[i] & pp[j];
        end
      end
      gg = gn;
      pp = pn;
    end
    return gg;
  endfunction

  logic              v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [N_BITS-1:0] g1_q, g1_d, p1_q, p1_d, h1_q, h1_d;
  logic [N_BITS-1:0] gp1_q, gp1_d, pp1_q, pp1_d, hp1_q, hp1_d;
  logic              cs1_q, cs1_d;
  logic [N_BITS-1:0] c0_q, c0_d, c1_q, c1_d, h2_q, h2_d, hp2_q, hp2_d;
  logic              cout2_q, cout2_d;
  logic [N_BITS-1:0] sum3_q, sum3_d;
  logic              wrap3_q, wrap3_d;
  logic              rdy1, rdy2, rdy3;
  logic [N_BITS-1:0] gpre0, gpre1;

  // Handshake: a stage may load whenever it is empty or the stage after it
  // can load this cycle; a transfer happens on valid & ready at the rising
  // edge. Ready ripples combinationally from out_ready so bubbles collapse.
  always_comb begin
    rdy3 = ~v3_q | out_ready;
    rdy2 = ~v2_q | rdy3;
    rdy1 = ~v1_q | rdy2;

    gpre0 = prefix_g(g1_q, p1_q);
    gpre1 = prefix_g(gp1_q, pp1_q);

    v1_d    = v1_q;
    g1_d    = g1_q;
    p1_d    = p1_q;
    h1_d    = h1_q;
    gp1_d   = gp1_q;
    pp1_d   = pp1_q;
    hp1_d   = hp1_q;
    cs1_d   = cs1_q;
    v2_d    = v2_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    h2_d    = h2_q;
    hp2_d   = hp2_q;
    cout2_d = cout2_q;
    v3_d    = v3_q;
    sum3_d  = sum3_q;
    wrap3_d = wrap3_q;

    if (rdy1) begin
      v1_d = in_valid;
      if (in_valid) begin
        g1_d  = in_g;
        p1_d  = in_p;
        h1_d  = in_h;
        gp1_d = in_gp;
        pp1_d = in_pp;
        hp1_d = in_hp;
        cs1_d = in_cs_cout;
      end
    end

    if (rdy2) begin
      v2_d = v1_q;
      if (v1_q) begin
        c0_d    = {gpre0[N_BITS-2:0], 1'b0};
        c1_d    = {gpre1[N_BITS-2:0], 1'b0};
        h2_d    = h1_q;
        hp2_d   = hp1_q;
        // Carry out of A+B+K: either the prefix chain or the carry-save row overflows.
        cout2_d = gpre1[N_BITS-1] | cs1_q;
      end
    end

    if (rdy3) begin
      v3_d = v2_q;
      if (v2_q) begin
        sum3_d  = cout2_q ? (hp2_q ^ c1_q) : (h2_q ^ c0_q);
        wrap3_d = cout2_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      g1_q    <= '0;
      p1_q    <= '0;
      h1_q    <= '0;
      gp1_q   <= '0;
      pp1_q   <= '0;
      hp1_q   <= '0;
      cs1_q   <= 1'b0;
      v2_q    <= 1'b0;
      c0_q    <= '0;
      c1_q    <= '0;
      h2_q    <= '0;
      hp2_q   <= '0;
      cout2_q <= 1'b0;
      v3_q    <= 1'b0;
      sum3_q  <= '0;
      wrap3_q <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      g1_q    <= g1_d;
      p1_q    <= p1_d;
      h1_q    <= h1_d;
      gp1_q   <= gp1_d;
      pp1_q   <= pp1_d;
      hp1_q   <= hp1_d;
      cs1_q   <= cs1_d;
      v2_q    <= v2_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      h2_q    <= h2_d;
      hp2_q   <= hp2_d;
      cout2_q <= cout2_d;
      v3_q    <= v3_d;
      sum3_q  <= sum3_d;
      wrap3_q <= wrap3_d;
    end
  end

  assign in_ready  = rdy1;
  assign out_valid = v3_q;
  assign out_sum   = sum3_q;
  assign out_wrap  = wrap3_q;

endmodule

// File: tb/tb_modadd_prefix_pipe.sv
// Bench for modadd_prefix_pipe at N_BITS=7/K=20 (M=108) and N_BITS=16/K=3 (M=65533).
// Operand vectors come from the hashed/enveloped cell rules; results are checked against (A+B) mod M.
module tb_modadd_prefix_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid7, in_ready7, out_valid7, out_ready7, out_wrap7, cs7;
  logic [6:0]  g7, p7, h7, gp7, pp7, hp7, out_sum7;
  logic        in_valid16, in_ready16, out_valid16, out_ready16, out_wrap16, cs16;
  logic [15:0] g16, p16, h16, gp16, pp16, hp16, out_sum16;

  modadd_prefix_pipe #(.N_BITS(7), .K_CONST(20)) u_dut7 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid7), .in_ready(in_ready7),
    .in_g(g7), .in_p(p7), .in_h(h7),
    .in_gp(gp7), .in_pp(pp7), .in_hp(hp7), .in_cs_cout(cs7),
    .out_valid(out_valid7), .out_ready(out_ready7),
    .out_sum(out_sum7), .out_wrap(out_wrap7)
  );

  modadd_prefix_pipe #(.N_BITS(16), .K_CONST(3)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .in_g(g16), .in_p(p16), .in_h(h16),
    .in_gp(gp16), .in_pp(pp16), .in_hp(hp16), .in_cs_cout(cs16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_sum(out_sum16), .out_wrap(out_wrap16)
  );

  int checks   = 0;
  int failures = 0;
  int pops7    = 0;
  int pops16   = 0;
  logic [16:0] exp_q7[$];
  logic [16:0] exp_q16[$];
  bit          stall7, stall16;
  logic [7:0]  held7;
  logic [16:0] held16;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Upstream rows: hashed cells on A,B; enveloped cells on the carry-save of A+B+K.
  function automatic void make_vec(input int n, input int k, input int a, input int b,
                                   output logic [31:0] g, output logic [31:0] p,
                                   output logic [31:0] h, output logic [31:0] gp,
                                   output logic [31:0] pp, output logic [31:0] hp,
                                   output logic cs);
    logic [31:0] av, bv, kv, mask, api, bpi, sh;
    av   = a;
    bv   = b;
    kv   = k;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    g    = av & bv & mask;
    p    = (av | bv) & mask;
    h    = (av ^ bv) & mask;
    api  = (av ^ bv ^ kv) & mask;
    bpi  = ((av & bv) | (av & kv) | (bv & kv)) & mask;
    sh   = (bpi << 1) & mask;
    gp   = api & sh;
    pp   = api | sh;
    hp   = api ^ sh;
    cs   = bpi[n-1];
  endfunction

  function automatic logic [16:0] model(input int n, input int k, input int a, input int b);
    longint m, s;
    m = (longint'(1) << n) - k;
    s = longint'(a) + longint'(b);
    if (s >= m) return {1'b1, 16'(s - m)};
    return {1'b0, 16'(s)};
  endfunction

  task automatic monitor();
    logic [16:0] e;
    if (!rst_n) begin
      stall7  = 1'b0;
      stall16 = 1'b0;
    end else begin
      if (stall7) begin
        chk("stall_valid7", out_valid7, 1);
        chk("stall_data7", {out_wrap7, out_sum7}, held7);
      end
      if (out_valid7 && out_ready7) begin
        if (exp_q7.size() == 0) chk("spurious_out7", out_valid7, 0);
        else begin
          e = exp_q7.pop_front();
          chk("sum7", out_sum7, e[15:0]);
          chk("wrap7", out_wrap7, e[16]);
          pops7++;
        end
      end
      stall7 = out_valid7 && !out_ready7;
      held7  = {out_wrap7, out_sum7};

      if (stall16) begin
        chk("stall_valid16", out_valid16, 1);
        chk("stall_data16", {out_wrap16, out_sum16}, held16);
      end
      if (out_valid16 && out_ready16) begin
        if (exp_q16.size() == 0) chk("spurious_out16", out_valid16, 0);
        else begin
          e = exp_q16.pop_front();
          chk("sum16", out_sum16, e[15:0]);
          chk("wrap16", out_wrap16, e[16]);
          pops16++;
        end
      end
      stall16 = out_valid16 && !out_ready16;
      held16  = {out_wrap16, out_sum16};
    end
  endtask

  // One clock cycle on DUT w (0: 7-bit, 1: 16-bit); the other DUT idles with out_ready=1.
  task automatic beat(input int w, input bit v, input bit ordy, input int a, input int b,
                      output bit acc);
    logic [31:0] g, p, h, gp, pp, hp;
    logic cs;
    int n, k;
    n = (w == 0) ? 7 : 16;
    k = (w == 0) ? 20 : 3;
    make_vec(n, k, a, b, g, p, h, gp, pp, hp, cs);
    in_valid7   = (w == 0) && v;
    out_ready7  = (w == 0) ? ordy : 1'b1;
    in_valid16  = (w == 1) && v;
    out_ready16 = (w == 1) ? ordy : 1'b1;
    if (w == 0) begin
      g7 = g[6:0]; p7 = p[6:0]; h7 = h[6:0];
      gp7 = gp[6:0]; pp7 = pp[6:0]; hp7 = hp[6:0]; cs7 = cs;
    end else begin
      g16 = g[15:0]; p16 = p[15:0]; h16 = h[15:0];
      gp16 = gp[15:0]; pp16 = pp[15:0]; hp16 = hp[15:0]; cs16 = cs;
    end
    @(negedge clk);
    monitor();
    acc = v && rst_n && ((w == 0) ? in_ready7 : in_ready16);
    if (acc) begin
      if (w == 0) exp_q7.push_back(model(n, k, a, b));
      else        exp_q16.push_back(model(n, k, a, b));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    bit acc;
    for (int i = 0; i < cycles; i++) beat(0, 1'b0, 1'b1, 0, 0, acc);
  endtask

  initial begin
    bit acc;
    int n_acc, p0, a, b;
    int dir_a[5] = '{10, 107, 107, 107, 0};
    int dir_b[5] = '{20, 1, 0, 107, 0};

    rst_n = 1'b0;
    in_valid7 = 1'b0; out_ready7 = 1'b1; in_valid16 = 1'b0; out_ready16 = 1'b1;
    g7 = '0; p7 = '0; h7 = '0; gp7 = '0; pp7 = '0; hp7 = '0; cs7 = 1'b0;
    g16 = '0; p16 = '0; h16 = '0; gp16 = '0; pp16 = '0; hp16 = '0; cs16 = 1'b0;
    #1;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      beat(0, 1'b1, 1'b1, 5, 6, acc);
      chk("rst_out_valid7", out_valid7, 0);
      chk("rst_out_sum7", out_sum7, 0);
      chk("rst_out_wrap7", out_wrap7, 0);
      chk("rst_in_ready7", in_ready7, 1);
      chk("rst_out_valid16", out_valid16, 0);
    end
    rst_n = 1'b1;
    idle(1);

    // Single op with reduction and its latency
    beat(0, 1'b1, 1'b1, 69, 45, acc);
    chk("first_accept", acc, 1);
    idle(1);
    chk("lat_not_yet", out_valid7, 0);
    @(posedge clk);
    #1;
    chk("lat_valid", out_valid7, 1);
    chk("lat_sum_69_45", out_sum7, 6);
    chk("lat_wrap_69_45", out_wrap7, 1);
    idle(2);

    // Directed boundary values, back to back
    for (int i = 0; i < 5; i++) beat(0, 1'b1, 1'b1, dir_a[i], dir_b[i], acc);
    idle(6);
    chk("directed_drained", exp_q7.size(), 0);

    // Back-to-back streaming
    p0 = pops7;
    n_acc = 0;
    for (int i = 0; i < 200; i++) begin
      a = $urandom_range(107);
      b = $urandom_range(107);
      beat(0, 1'b1, 1'b1, a, b, acc);
      n_acc += int'(acc);
    end
    chk("stream_accepts", n_acc, 200);
    chk("stream_outs", pops7 - p0, 197);
    idle(6);

    // Back-pressure from an empty pipeline
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      beat(0, 1'b1, 1'b0, $urandom_range(107), $urandom_range(107), acc);
      n_acc += int'(acc);
    end
    chk("bp_accepts", n_acc, 3);
    chk("bp_in_ready", in_ready7, 0);
    for (int i = 0; i < 20; i++) beat(0, 1'b1, 1'b1, $urandom_range(107), $urandom_range(107), acc);
    idle(6);
    chk("bp_drained", exp_q7.size(), 0);

    // Reset pulse with three bundles in flight
    for (int i = 0; i < 3; i++) beat(0, 1'b1, 1'b0, $urandom_range(107), $urandom_range(107), acc);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid7, 0);
    chk("mid_rst_out_sum", out_sum7, 0);
    chk("mid_rst_in_ready", in_ready7, 1);
    exp_q7.delete();
    beat(0, 1'b0, 1'b1, 0, 0, acc);
    rst_n = 1'b1;
    p0 = pops7;
    idle(8);
    chk("post_rst_no_outputs", pops7 - p0, 0);

    // Random valid/ready toggling at both widths
    for (int w = 0; w < 2; w++) begin
      n_acc = 0;
      for (int c = 0; c < 8000 && n_acc < 1000; c++) begin
        a = (w == 0) ? $urandom_range(107) : $urandom_range(65532);
        b = (w == 0) ? $urandom_range(107) : $urandom_range(65532);
        beat(w, ($urandom_range(3) != 0), ($urandom_range(1) == 1), a, b, acc);
        n_acc += int'(acc);
      end
      chk((w == 0) ? "rand_ops7" : "rand_ops16", n_acc, 1000);
      for (int i = 0; i < 8; i++) beat(w, 1'b0, 1'b1, 0, 0, acc);
    end

    chk("final_q7_empty", exp_q7.size(), 0);
    chk("final_q16_empty", exp_q16.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
